// File: rtl/traffic_light_monitor.sv
// ---------------------------------------------------------------------------
// traffic_light_monitor
//
// Receive-side checker for the 2-bit light_color bus driven by the traffic
// light controller. Each enabled cycle the bus is sampled and decoded into a
// registered one-hot go/caution/stop indication. The sample is also checked
// against the legal colour order (RED->GREEN->YELLOW->RED) and against the
// required dwell time of each colour. Completed, timing-checked cycles are
// counted. All outputs change one cycle after the sample that caused them.
//
// Ports
//   clk          in   1   single clock, rising edge
//   reset        in   1   synchronous, active-high
//   enable       in   1   1 = sample light_color this cycle, 0 = hold all state
//   light_color  in   2   00 GREEN, 01 YELLOW, 10 RED, 11 illegal
//   clear_err    in   1   synchronous clear of the sticky error flags
//   go           out  1   last accepted colour is GREEN
//   caution      out  1   last accepted colour is YELLOW
//   stop         out  1   last accepted colour is RED
//   err_seq      out  1   sticky: illegal colour transition seen
//   err_time     out  1   sticky: dwell over- or under-run seen
//   err_code     out  1   sticky: encoding 2'b11 seen
//   err_any      out  1   OR of the three error flags
//   dwell_cnt    out  CW  enabled cycles the current colour has been held
//   cycle_count  out  CW  completed GREEN->YELLOW->RED cycles (wraps)
// ---------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int GREEN_CYCLES  = 6,
    parameter int YELLOW_CYCLES = 3,
    parameter int RED_CYCLES    = 5,
    parameter int CW            = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [1:0]    light_color,
    input  logic          clear_err,
    output logic          go,
    output logic          caution,
    output logic          stop,
    output logic          err_seq,
    output logic          err_time,
    output logic          err_code,
    output logic          err_any,
    output logic [CW-1:0] dwell_cnt,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic {
        SYNC,
        TRACK
    } state_t;

    localparam logic [1:0] GREEN   = 2'b00;
    localparam logic [1:0] YELLOW  = 2'b01;
    localparam logic [1:0] RED     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    localparam logic [CW-1:0] GREEN_EXP  = CW'(GREEN_CYCLES);
    localparam logic [CW-1:0] YELLOW_EXP = CW'(YELLOW_CYCLES);
    localparam logic [CW-1:0] RED_EXP    = CW'(RED_CYCLES);
    localparam logic [CW-1:0] DWELL_MAX  = '1;

    // Required dwell for the colour that is being left or held.
    function automatic logic [CW-1:0] expectedDwell(input logic [1:0] color);
        logic [CW-1:0] result;
        case (color)
            GREEN:   result = GREEN_EXP;
            YELLOW:  result = YELLOW_EXP;
            default: result = RED_EXP;
        endcase
        return result;
    endfunction

    // The only three transitions a healthy controller ever makes.
    function automatic logic legalStep(input logic [1:0] fromColor, input logic [1:0] toColor);
        return ((fromColor == RED)    && (toColor == GREEN))  ||
               ((fromColor == GREEN)  && (toColor == YELLOW)) ||
               ((fromColor == YELLOW) && (toColor == RED));
    endfunction

    // One-hot lamp pattern, ordered {go, caution, stop}.
    function automatic logic [2:0] lampOf(input logic [1:0] color);
        logic [2:0] result;
        case (color)
            GREEN:   result = 3'b100;
            YELLOW:  result = 3'b010;
            default: result = 3'b001;
        endcase
        return result;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    prev_q, prev_d;
    logic [2:0]    lamp_q, lamp_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          errSeq_q, errSeq_d;
    logic          errTime_q, errTime_d;
    logic          errCode_q, errCode_d;

    logic          seqEvent;
    logic          timeEvent;
    logic          codeEvent;
    logic [CW-1:0] dwellInc;

    assign dwellInc = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;

    // Next-state evaluation for one sample. A held colour grows the dwell
    // count and flags an overrun the moment it exceeds the limit, so a
    // transition only has to look for underruns. The illegal code is
    // reported but otherwise leaves the tracking state untouched. Illegal
    // transitions are reported yet still accepted so the checker keeps
    // following whatever the controller is actually showing. The first
    // segment after reset is of unknown length, so SYNC skips the dwell check.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        lamp_d    = lamp_q;
        dwell_d   = dwell_q;
        cycles_d  = cycles_q;
        seqEvent  = 1'b0;
        timeEvent = 1'b0;
        codeEvent = 1'b0;

        if (enable) begin
            if (light_color == ILLEGAL) begin
                codeEvent = 1'b1;
            end else if (light_color == prev_q) begin
                dwell_d = dwellInc;
                if ((state_q == TRACK) && (dwellInc > expectedDwell(prev_q))) begin
                    timeEvent = 1'b1;
                end
            end else begin
                if (!legalStep(prev_q, light_color)) begin
                    seqEvent = 1'b1;
                end
                if ((state_q == TRACK) && (dwell_q < expectedDwell(prev_q))) begin
                    timeEvent = 1'b1;
                end
                if ((state_q == TRACK) && (prev_q == YELLOW) && (light_color == RED)) begin
                    cycles_d = cycles_q + 1'b1;
                end
                state_d = TRACK;
                prev_d  = light_color;
                lamp_d  = lampOf(light_color);
                dwell_d = {{(CW-1){1'b0}}, 1'b1};
            end
        end

        errSeq_d  = (errSeq_q  & ~clear_err) | seqEvent;
        errTime_d = (errTime_q & ~clear_err) | timeEvent;
        errCode_d = (errCode_q & ~clear_err) | codeEvent;
    end

    // Single state register for the whole monitor. Reset wins over enable
    // so the checker always comes back to a known RED/SYNC starting point.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SYNC;
            prev_q    <= RED;
            lamp_q    <= 3'b001;
            dwell_q   <= '0;
            cycles_q  <= '0;
            errSeq_q  <= 1'b0;
            errTime_q <= 1'b0;
            errCode_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            lamp_q    <= lamp_d;
            dwell_q   <= dwell_d;
            cycles_q  <= cycles_d;
            errSeq_q  <= errSeq_d;
            errTime_q <= errTime_d;
            errCode_q <= errCode_d;
        end
    end

    assign go          = lamp_q[2];
    assign caution     = lamp_q[1];
    assign stop        = lamp_q[0];
    assign err_seq     = errSeq_q;
    assign err_time    = errTime_q;
    assign err_code    = errCode_q;
    assign err_any     = errSeq_q | errTime_q | errCode_q;
    assign dwell_cnt   = dwell_q;
    assign cycle_count = cycles_q;

endmodule
